// File: rtl/cmd_assembler_pkg.sv
// ---------------------------------------------------------------------------
// cmd_assembler_pkg
// Shared constants for the command assembler:
//   - receive FSM state encodings (RX_IDLE, RX_WAIT_LO)
//   - transmit FSM state encodings (TX_IDLE, TX_BUSY)
//   - POS_ACK: the conventional positive-acknowledge response byte
// ---------------------------------------------------------------------------
package cmd_assembler_pkg;

  // Receive FSM: waiting for the high byte, or holding it and waiting for
  // the low byte.
  localparam logic [0:0] RX_IDLE    = 1'b0;
  localparam logic [0:0] RX_WAIT_LO = 1'b1;

  // Transmit FSM: transmitter free, or a byte is in flight.
  localparam logic [0:0] TX_IDLE = 1'b0;
  localparam logic [0:0] TX_BUSY = 1'b1;

  // Positive acknowledge response byte.
  localparam logic [7:0] POS_ACK = 8'hA5;

endpackage

// File: rtl/cmd_assembler_resp_buf.sv
// ---------------------------------------------------------------------------
// cmd_assembler_resp_buf
// Response transmit sequencer with a one-deep pending buffer. A response
// requested while the UART transmitter is busy is parked in the buffer and
// launched as soon as the current byte completes; a newer request replaces
// an older parked one.
//
// Ports:
//   i_clk       system clock (rising edge)
//   i_rst_n     asynchronous active-low reset
//   i_snd_resp  one-cycle request to transmit i_resp
//   i_resp      response byte
//   i_tx_done   UART transmitter finished the current byte
//   o_trmt      one-cycle pulse starting a UART transmit (registered)
//   o_tx_data   byte presented to the transmitter (registered, held)
// ---------------------------------------------------------------------------
module cmd_assembler_resp_buf
  import cmd_assembler_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_snd_resp,
  input  logic [7:0] i_resp,
  input  logic       i_tx_done,
  output logic       o_trmt,
  output logic [7:0] o_tx_data
);

  logic [0:0] r_state;
  logic [7:0] r_pend;
  logic       r_pend_vld;
  logic       r_trmt;
  logic [7:0] r_tx_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= TX_IDLE;
      r_pend     <= 8'h00;
      r_pend_vld <= 1'b0;
      r_trmt     <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_trmt <= 1'b0;
      case (r_state)
        TX_IDLE: begin
          if (i_snd_resp) begin
            r_tx_data <= i_resp;
            r_trmt    <= 1'b1;
            r_state   <= TX_BUSY;
          end
        end
        default: begin
          if (i_tx_done) begin
            if (i_snd_resp) begin
              // A request arriving with tx_done is the newest one: it would
              // overwrite the pending slot and be launched immediately, so
              // bypass the slot and drop whatever was parked there.
              r_tx_data  <= i_resp;
              r_trmt     <= 1'b1;
              r_pend_vld <= 1'b0;
            end else if (r_pend_vld) begin
              r_tx_data  <= r_pend;
              r_trmt     <= 1'b1;
              r_pend_vld <= 1'b0;
            end else begin
              r_state <= TX_IDLE;
            end
          end else if (i_snd_resp) begin
            r_pend     <= i_resp;
            r_pend_vld <= 1'b1;
          end
        end
      endcase
    end
  end

  assign o_trmt    = r_trmt;
  assign o_tx_data = r_tx_data;

endmodule

// File: rtl/cmd_assembler.sv
// ---------------------------------------------------------------------------
// cmd_assembler
// Builds 16-bit commands from pairs of UART bytes (high byte first) and
// sequences response bytes back to the UART transmitter. A high byte with no
// low byte following within the inter-byte timeout is discarded and flagged
// with frame_err. Receive and transmit paths are fully independent.
//
// Parameters:
//   FAST_SIM  1 shortens the inter-byte timeout to a 10-bit counter
//   TMO_BITS  timeout counter width when FAST_SIM = 0
//
// Ports:
//   clk          system clock (rising edge)
//   rst_n        asynchronous active-low reset
//   rx_rdy       receiver holds a valid byte (level until cleared)
//   rx_data      received byte
//   clr_rx_rdy   one-cycle pulse consuming the current byte (combinational)
//   cmd          assembled command {high, low}
//   cmd_rdy      cmd valid (level)
//   clr_cmd_rdy  consumer acknowledges cmd
//   frame_err    one-cycle pulse: high byte discarded on timeout
//   snd_resp     one-cycle request to transmit resp
//   resp         response byte
//   trmt         one-cycle pulse starting a UART transmit
//   tx_data      byte presented to the transmitter
//   tx_done      transmitter finished the current byte
// ---------------------------------------------------------------------------
module cmd_assembler
  import cmd_assembler_pkg::*;
#(
  parameter int FAST_SIM = 0,
  parameter int TMO_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frame_err,
  input  logic        snd_resp,
  input  logic [7:0]  resp,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done
);

  localparam int            TW        = (FAST_SIM != 0) ? 10 : TMO_BITS;
  localparam logic [TW-1:0] TMO_MAX   = '1;
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  logic [0:0]    r_rx_state;
  logic [7:0]    r_hi;
  logic [TW-1:0] r_timer;
  logic          r_clr_d;
  logic [15:0]   r_cmd;
  logic          r_cmd_rdy;
  logic          r_frame_err;

  logic w_accept;
  logic w_timeout;

  // Both receive states consume a byte when one is presented. The receiver
  // needs a cycle to drop rx_rdy after being cleared, so the cycle right
  // after a clear is ignored; this also keeps clr_rx_rdy from ever being
  // high on two consecutive cycles. rst_n gating keeps it low in reset.
  assign w_accept   = rst_n & rx_rdy & ~r_clr_d;
  assign clr_rx_rdy = w_accept;

  // A byte arriving on the very cycle the timer is all-ones still counts as
  // the low byte, so the timeout only fires when nothing is accepted.
  assign w_timeout = (r_rx_state == RX_WAIT_LO) && !w_accept && (r_timer == TMO_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state  <= RX_IDLE;
      r_hi        <= 8'h00;
      r_timer     <= '0;
      r_clr_d     <= 1'b0;
      r_cmd       <= 16'h0000;
      r_cmd_rdy   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_clr_d     <= w_accept;
      r_frame_err <= w_timeout;

      case (r_rx_state)
        RX_IDLE: begin
          if (w_accept) begin
            r_hi       <= rx_data;
            r_timer    <= '0;
            r_rx_state <= RX_WAIT_LO;
          end
        end
        RX_WAIT_LO: begin
          if (w_accept) begin
            r_cmd      <= {r_hi, rx_data};
            r_timer    <= '0;
            r_rx_state <= RX_IDLE;
          end else if (w_timeout) begin
            r_hi       <= 8'h00;
            r_timer    <= '0;
            r_rx_state <= RX_IDLE;
          end else begin
            r_timer <= r_timer + TIMER_ONE;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase

      // Completion of a command takes priority over the consumer's clear;
      // the start of a new command invalidates the previous one.
      if ((r_rx_state == RX_WAIT_LO) && w_accept) begin
        r_cmd_rdy <= 1'b1;
      end else if (((r_rx_state == RX_IDLE) && w_accept) || clr_cmd_rdy) begin
        r_cmd_rdy <= 1'b0;
      end
    end
  end

  assign cmd       = r_cmd;
  assign cmd_rdy   = r_cmd_rdy;
  assign frame_err = r_frame_err;

  cmd_assembler_resp_buf u_resp_buf (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_snd_resp (snd_resp),
    .i_resp     (resp),
    .i_tx_done  (tx_done),
    .o_trmt     (trmt),
    .o_tx_data  (tx_data)
  );

endmodule

// File: tb/tb_cmd_assembler.sv
// ---------------------------------------------------------------------------
// tb_cmd_assembler
// Directed bench for cmd_assembler (FAST_SIM=1, 10-bit timeout). A per-cycle
// vector table covers command assembly, cmd_rdy handshake and the response
// buffer; hand-written sequences cover the inter-byte timeout, the
// last-cycle low byte and reset in the middle of a command.
// Inputs change on the falling edge; clr_rx_rdy is sampled 1 ns after the
// inputs change, registered outputs 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_cmd_assembler;
  import cmd_assembler_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_cmd_rdy = 1'b0;
  logic        snd_resp = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        tx_done = 1'b0;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frame_err;
  logic        trmt;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  cmd_assembler #(.FAST_SIM(1), .TMO_BITS(20)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .frame_err   (frame_err),
    .snd_resp    (snd_resp),
    .resp        (resp),
    .trmt        (trmt),
    .tx_data     (tx_data),
    .tx_done     (tx_done)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One table row = one clock cycle of inputs plus the expected outputs
  // (clr_rx_rdy before the edge, registered outputs after it).
  typedef struct {
    logic        rr;
    logic [7:0]  rd;
    logic        cc;
    logic        sn;
    logic [7:0]  rs;
    logic        dn;
    logic        e_clr;
    logic [15:0] e_cmd;
    logic        e_rdy;
    logic        e_trmt;
    logic [7:0]  e_txd;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rr, input logic [7:0] rd, input logic cc,
                              input logic sn, input logic [7:0] rs, input logic dn,
                              input logic e_clr, input logic [15:0] e_cmd,
                              input logic e_rdy, input logic e_trmt, input logic [7:0] e_txd);
    vec_t v;
    v.rr = rr; v.rd = rd; v.cc = cc; v.sn = sn; v.rs = rs; v.dn = dn;
    v.e_clr = e_clr; v.e_cmd = e_cmd; v.e_rdy = e_rdy; v.e_trmt = e_trmt; v.e_txd = e_txd;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rx_rdy = v.rr; rx_data = v.rd; clr_cmd_rdy = v.cc;
    snd_resp = v.sn; resp = v.rs; tx_done = v.dn;
    #1;
    chk1($sformatf("vec%0d clr_rx_rdy", idx), clr_rx_rdy, v.e_clr);
    @(posedge clk);
    #1;
    chk16($sformatf("vec%0d cmd", idx), cmd, v.e_cmd);
    chk1($sformatf("vec%0d cmd_rdy", idx), cmd_rdy, v.e_rdy);
    chk1($sformatf("vec%0d frame_err", idx), frame_err, 1'b0);
    chk1($sformatf("vec%0d trmt", idx), trmt, v.e_trmt);
    chk8($sformatf("vec%0d tx_data", idx), tx_data, v.e_txd);
    $display("vec %0d: clr_rx_rdy=%b cmd=%04h cmd_rdy=%b trmt=%b tx_data=%02h",
             idx, clr_rx_rdy, cmd, cmd_rdy, trmt, tx_data);
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
    snd_resp = 1'b0; resp = 8'h00; tx_done = 1'b0;
  endtask

  // Present a byte, expect it consumed, then hold rx_rdy one more cycle as
  // a slow receiver would and expect that stale cycle to be ignored.
  task automatic send_byte(input logic [7:0] b, input string tag);
    @(negedge clk);
    rx_rdy = 1'b1; rx_data = b;
    #1;
    chk1({tag, " clr_rx_rdy"}, clr_rx_rdy, 1'b1);
    @(negedge clk);
    #1;
    chk1({tag, " stale clr_rx_rdy"}, clr_rx_rdy, 1'b0);
    rx_rdy = 1'b0; rx_data = 8'h00;
    $display("byte %02h sent (%s)", b, tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk16({tag, " cmd"}, cmd, 16'h0000);
    chk1({tag, " cmd_rdy"}, cmd_rdy, 1'b0);
    chk1({tag, " frame_err"}, frame_err, 1'b0);
    chk1({tag, " trmt"}, trmt, 1'b0);
    chk8({tag, " tx_data"}, tx_data, 8'h00);
    chk1({tag, " clr_rx_rdy"}, clr_rx_rdy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_ferr;
    int n_ferr;

    //          rr  rd     cc  sn  rs       dn   clr  cmd       rdy  trmt txd
    vecs[0]  = mk(1, 8'h12, 0, 0, 8'h00,   0,   1, 16'h0000, 0,   0, 8'h00);
    vecs[1]  = mk(1, 8'h12, 0, 0, 8'h00,   0,   0, 16'h0000, 0,   0, 8'h00);
    vecs[2]  = mk(0, 8'h00, 0, 0, 8'h00,   0,   0, 16'h0000, 0,   0, 8'h00);
    vecs[3]  = mk(0, 8'h00, 0, 0, 8'h00,   0,   0, 16'h0000, 0,   0, 8'h00);
    vecs[4]  = mk(0, 8'h00, 0, 0, 8'h00,   0,   0, 16'h0000, 0,   0, 8'h00);
    vecs[5]  = mk(1, 8'h34, 0, 0, 8'h00,   0,   1, 16'h1234, 1,   0, 8'h00);
    vecs[6]  = mk(1, 8'h34, 0, 0, 8'h00,   0,   0, 16'h1234, 1,   0, 8'h00);
    vecs[7]  = mk(0, 8'h00, 1, 0, 8'h00,   0,   0, 16'h1234, 0,   0, 8'h00);
    vecs[8]  = mk(1, 8'hAB, 0, 0, 8'h00,   0,   1, 16'h1234, 0,   0, 8'h00);
    vecs[9]  = mk(1, 8'hAB, 0, 0, 8'h00,   0,   0, 16'h1234, 0,   0, 8'h00);
    vecs[10] = mk(1, 8'hCD, 1, 0, 8'h00,   0,   1, 16'hABCD, 1,   0, 8'h00);
    vecs[11] = mk(1, 8'hCD, 0, 0, 8'h00,   0,   0, 16'hABCD, 1,   0, 8'h00);
    vecs[12] = mk(0, 8'h00, 0, 1, POS_ACK, 0,   0, 16'hABCD, 1,   1, 8'hA5);
    vecs[13] = mk(0, 8'h00, 0, 1, 8'h5A,   0,   0, 16'hABCD, 1,   0, 8'hA5);
    vecs[14] = mk(0, 8'h00, 0, 1, 8'h33,   0,   0, 16'hABCD, 1,   0, 8'hA5);
    vecs[15] = mk(0, 8'h00, 0, 0, 8'h00,   1,   0, 16'hABCD, 1,   1, 8'h33);
    vecs[16] = mk(0, 8'h00, 0, 0, 8'h00,   0,   0, 16'hABCD, 1,   0, 8'h33);
    vecs[17] = mk(0, 8'h00, 0, 0, 8'h00,   1,   0, 16'hABCD, 1,   0, 8'h33);
    vecs[18] = mk(0, 8'h00, 0, 1, 8'h77,   0,   0, 16'hABCD, 1,   1, 8'h77);
    vecs[19] = mk(0, 8'h00, 0, 1, 8'h44,   1,   0, 16'hABCD, 1,   1, 8'h44);
    vecs[20] = mk(0, 8'h00, 0, 0, 8'h00,   1,   0, 16'hABCD, 1,   0, 8'h44);

    // Reset state
    #23;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table: assembly, stale rx_rdy, cmd_rdy handshake, response buffer
    for (int i = 0; i < NV; i++) apply(vecs[i], i);
    idle_inputs();

    // Timeout: the timer is all-ones during WAIT_LO cycle 1023; frame_err
    // is registered, so it shows after the 1024th edge following the
    // accept edge.
    @(negedge clk);
    rx_rdy = 1'b1; rx_data = 8'h40;
    #1;
    chk1("tmo clr_rx_rdy", clr_rx_rdy, 1'b1);
    @(posedge clk);
    #1;
    chk1("tmo cmd_rdy cleared by new hi", cmd_rdy, 1'b0);
    @(negedge clk);
    #1;
    chk1("tmo stale clr_rx_rdy", clr_rx_rdy, 1'b0);
    rx_rdy = 1'b0; rx_data = 8'h00;
    first_ferr = 0;
    n_ferr = 0;
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clk);
      #1;
      if (frame_err) begin
        if (first_ferr == 0) first_ferr = k;
        n_ferr++;
      end
    end
    chk_int("tmo frame_err edge", first_ferr, 1024);
    chk_int("tmo frame_err pulses", n_ferr, 1);
    chk16("tmo cmd unchanged", cmd, 16'hABCD);
    chk1("tmo cmd_rdy unchanged", cmd_rdy, 1'b0);
    $display("timeout: frame_err after %0d edges, %0d pulse(s)", first_ferr, n_ferr);
    send_byte(8'h56, "post-tmo hi");
    send_byte(8'h78, "post-tmo lo");
    chk16("post-tmo cmd", cmd, 16'h5678);
    chk1("post-tmo cmd_rdy", cmd_rdy, 1'b1);

    // Low byte on the exact cycle the timer is all-ones
    @(negedge clk);
    rx_rdy = 1'b1; rx_data = 8'h11;
    #1;
    chk1("edge clr_rx_rdy hi", clr_rx_rdy, 1'b1);
    @(posedge clk);
    #1;
    rx_rdy = 1'b0; rx_data = 8'h00;
    n_ferr = 0;
    for (int k = 1; k <= 1023; k++) begin
      @(posedge clk);
      #1;
      if (frame_err) n_ferr++;
    end
    rx_rdy = 1'b1; rx_data = 8'h22;
    #1;
    chk1("edge clr_rx_rdy lo", clr_rx_rdy, 1'b1);
    @(posedge clk);
    #1;
    rx_rdy = 1'b0; rx_data = 8'h00;
    chk_int("edge early frame_err", n_ferr, 0);
    chk1("edge frame_err", frame_err, 1'b0);
    chk16("edge cmd", cmd, 16'h1122);
    chk1("edge cmd_rdy", cmd_rdy, 1'b1);
    @(posedge clk);
    #1;
    chk1("edge frame_err late", frame_err, 1'b0);
    $display("last-cycle low byte: cmd=%04h cmd_rdy=%b", cmd, cmd_rdy);

    // Reset in the middle of a command with a response parked
    @(negedge clk);
    snd_resp = 1'b1; resp = 8'h61;
    @(negedge clk);
    resp = 8'h62;
    @(negedge clk);
    snd_resp = 1'b0; resp = 8'h00;
    #1;
    chk8("pre-rst tx_data", tx_data, 8'h61);
    send_byte(8'h99, "pre-rst hi");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("mid-cmd reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tx_done = 1'b1;
    @(posedge clk);
    #1;
    chk1("post-rst no pending trmt", trmt, 1'b0);
    tx_done = 1'b0;
    n_ferr = 0;
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clk);
      #1;
      if (frame_err) n_ferr++;
    end
    chk_int("post-rst frame_err pulses", n_ferr, 0);
    send_byte(8'h01, "post-rst hi");
    send_byte(8'h02, "post-rst lo");
    chk16("post-rst cmd", cmd, 16'h0102);
    chk1("post-rst cmd_rdy", cmd_rdy, 1'b1);
    $display("reset mid-command: cmd=%04h cmd_rdy=%b", cmd, cmd_rdy);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
